imem_read_responder: RTL and testbench

//  Responder end of the core's instruction-fetch read interface (i_mem_read / i_mem_valid).
//  - Accepts byte-addressed fetch requests and queues up to 2 outstanding requests.
//  - Returns each instruction word in order, after a fixed latency, tagged with its request address.
//  - Bench and FPGA stand-in for the I-cache/memory path behind the fetch stage.

---
 rtl/imem_read_responder.sv | 136 +++++++++++++
 tb/tb_imem_read_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_read_responder                                              |
// | Brief   : In-order, fixed-latency responder for instruction fetch reads.   |
// |           It has a 2-entry request queue. IMEM_RESP_ISP_EN adds an         |
// |           in-system program write port.                                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module imem_read_responder #(
  parameter int ADDRESS_BITS = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_BITS   = 10,
  parameter int LATENCY      = 2,
  parameter     PROGRAM      = ""
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    read,
  input  logic [ADDRESS_BITS-1:0] read_address,
  input  logic                    flush,
`ifdef IMEM_RESP_ISP_EN
  input  logic                    isp_write,
  input  logic [ADDRESS_BITS-1:0] isp_address,
  input  logic [DATA_WIDTH-1:0]   isp_data,
`endif
  output logic                    ready,
  output logic                    valid,
  output logic [ADDRESS_BITS-1:0] out_addr,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic                    overflow
);

  localparam int         c_DEPTH    = 1 << INDEX_BITS;
  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

  logic [DATA_WIDTH-1:0]   r_mem [c_DEPTH];
  logic [ADDRESS_BITS-1:0] r_addr [2];
  logic [3:0]              r_cnt [2];
  logic [1:0]              r_occ;

  logic [ADDRESS_BITS-1:0] w_addr_n [2];
  logic [3:0]              w_cnt_n [2];
  logic [1:0]              w_occ_n;
  logic [1:0]              w_occ_base;
  logic [3:0]              w_dec0;
  logic [3:0]              w_dec1;
  logic                    w_pop;
  logic                    w_push;
  logic [INDEX_BITS-1:0]   w_head_idx;

  logic                    w_wr_en;
  logic [INDEX_BITS-1:0]   w_wr_idx;
  logic [DATA_WIDTH-1:0]   w_wr_data;

`ifdef IMEM_RESP_ISP_EN
  logic w_unused_isp;
  assign w_unused_isp = ^isp_address;
  assign w_wr_en      = isp_write;
  assign w_wr_idx     = isp_address[INDEX_BITS+1:2];
  assign w_wr_data    = isp_data;
`else
  assign w_wr_en      = 1'b0;
  assign w_wr_idx     = '0;
  assign w_wr_data    = '0;
`endif

  assign ready      = (r_occ < 2'd2);
  assign w_head_idx = r_addr[0][INDEX_BITS+1:2];
  // A flush suppresses the retirement that would otherwise happen on the same edge.
  assign w_pop      = (r_occ != 2'd0) && (r_cnt[0] == 4'd0) && !flush;
  assign w_push     = read && (ready || flush);

  always_comb begin
    w_dec0     = (r_cnt[0] != 4'd0) ? r_cnt[0] - 4'd1 : 4'd0;
    w_dec1     = (r_cnt[1] != 4'd0) ? r_cnt[1] - 4'd1 : 4'd0;
    w_addr_n   = r_addr;
    w_cnt_n[0] = w_dec0;
    w_cnt_n[1] = w_dec1;
    w_occ_base = r_occ;

    if (flush) begin
      w_occ_base = 2'd0;
    end else if (w_pop) begin
      w_addr_n[0] = r_addr[1];
      w_cnt_n[0]  = w_dec1;
      w_occ_base  = r_occ - 2'd1;
    end

    w_occ_n = w_occ_base;
    if (w_push) begin
      if (w_occ_base == 2'd0) begin
        w_addr_n[0] = read_address;
        w_cnt_n[0]  = c_CNT_INIT;
      end else begin
        w_addr_n[1] = read_address;
        w_cnt_n[1]  = c_CNT_INIT;
      end
      w_occ_n = w_occ_base + 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr[0]   <= '0;
      r_addr[1]   <= '0;
      r_cnt[0]    <= '0;
      r_cnt[1]    <= '0;
      r_occ       <= 2'd0;
      valid       <= 1'b0;
      out_addr    <= '0;
      instruction <= '0;
      overflow    <= 1'b0;
    end else begin
      r_addr <= w_addr_n;
      r_cnt  <= w_cnt_n;
      r_occ  <= w_occ_n;
      valid  <= w_pop;
      if (w_pop) begin
        out_addr    <= r_addr[0];
        instruction <= r_mem[w_head_idx];
      end
      if (read && !ready && !flush) begin
        overflow <= 1'b1;
      end
    end
  end

  // Same-edge write and read return the old word through non-blocking update order.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_read_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_imem_read_responder                                           |
// | Brief   : Self-checking bench with a vector table, a scoreboard and        |
// |           corner-case sequences.                                           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_imem_read_responder;

`ifdef IMEM_RESP_ISP_EN
  localparam int c_LAT = 1;
`else
  localparam int c_LAT = 2;
`endif

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    int          gap;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        read;
  logic [11:0] read_address;
  logic        flush;
  logic        ready;
  logic        valid;
  logic [11:0] out_addr;
  logic [31:0] instruction;
  logic        overflow;
`ifdef IMEM_RESP_ISP_EN
  logic        isp_write;
  logic [11:0] isp_address;
  logic [31:0] isp_data;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic        m_ovf   = 1'b0;
  logic [31:0] m_mem [1024];
  exp_t        sb [$];
  vec_t        vecs [8];

  imem_read_responder #(
    .ADDRESS_BITS(12), .DATA_WIDTH(32), .INDEX_BITS(10), .LATENCY(c_LAT), .PROGRAM("")
  ) u_dut (
    .clock(clock), .reset(reset), .read(read), .read_address(read_address), .flush(flush),
`ifdef IMEM_RESP_ISP_EN
    .isp_write(isp_write), .isp_address(isp_address), .isp_data(isp_data),
`endif
    .ready(ready), .valid(valid), .out_addr(out_addr), .instruction(instruction),
    .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pending();
    int n = 0;
    foreach (sb[i]) if (sb[i].due > cyc) n++;
    return n;
  endfunction

  // Response monitor: every valid must match the head of the scoreboard on its due cycle.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {52'd0, out_addr}, 64'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("resp_addr", 64'(out_addr), 64'(e.addr));
          chk("resp_data", 64'(instruction), 64'(e.data));
          chk("resp_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        chk("missing_valid", {52'd0, e.addr}, 64'hFFFF_FFFF);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Drives one request for the next edge and predicts acceptance from the bench's own occupancy.
  task automatic issue(input logic [11:0] a, input logic fl);
    logic exp_ready;
    exp_t e;
    exp_ready = (pending() < 2);
    chk("ready_before_req", 64'(ready), 64'(exp_ready));
    read = 1'b1;
    read_address = a;
    flush = fl;
    if (fl) begin
      for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].due > cyc) sb.delete(i);
    end
    if (exp_ready || fl) begin
      e.addr = a;
      e.data = m_mem[a[11:2]];
      e.due  = cyc + 1 + c_LAT;
      sb.push_back(e);
    end else if (!fl) begin
      m_ovf = 1'b1;
    end
    tick();
    read = 1'b0;
    flush = 1'b0;
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  initial begin
    read = 1'b0;
    read_address = '0;
    flush = 1'b0;
    reset = 1'b0;
`ifdef IMEM_RESP_ISP_EN
    isp_write = 1'b0;
    isp_address = '0;
    isp_data = '0;
`endif
    for (int i = 0; i < 1024; i++) begin
      m_mem[i] = $urandom;
      u_dut.r_mem[i] = m_mem[i];
    end
    vecs[0] = '{12'h010, 3};
    vecs[1] = '{12'h000, 0};
    vecs[2] = '{12'h004, 4};
    vecs[3] = '{12'hFFC, 1};
    vecs[4] = '{12'h013, 0};
    vecs[5] = '{12'h3A6, 4};
    vecs[6] = '{12'h800, 5};
    vecs[7] = '{12'h7FC, 2};

    idle(3);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_out_addr", 64'(out_addr), 64'd0);
    chk("rst_instruction", 64'(instruction), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b1;
    idle(2);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].addr, 1'b0);
      idle(vecs[i].gap);
    end
    idle(c_LAT + 3);

    // Back-to-back pair fills the queue; ready returns once the head has retired.
    issue(12'h000, 1'b0);
    issue(12'h004, 1'b0);
    chk("ready_full", 64'(ready), 64'd0);
    idle(c_LAT);
    chk("ready_after_first_valid", 64'(ready), 64'd1);
    idle(c_LAT + 3);

    // Third request while full is dropped and latches overflow.
    issue(12'h100, 1'b0);
    issue(12'h104, 1'b0);
    issue(12'h108, 1'b0);
    idle(c_LAT + 6);
    chk("overflow_sticky", 64'(overflow), 64'd1);

    // Flush on the retire edge of 0x020, with a fresh request on the same edge.
    issue(12'h020, 1'b0);
    idle(c_LAT - 1);
    issue(12'h040, 1'b1);
    idle(c_LAT + 3);

    // Asynchronous reset with two requests outstanding.
    issue(12'h200, 1'b0);
    issue(12'h204, 1'b0);
    reset = 1'b0;
    sb.delete();
    m_ovf = 1'b0;
    #2;
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_out_addr", 64'(out_addr), 64'd0);
    chk("mid_rst_instruction", 64'(instruction), 64'd0);
    chk("mid_rst_overflow", 64'(overflow), 64'd0);
    chk("mid_rst_ready", 64'(ready), 64'd1);
    idle(2);
    reset = 1'b1;
    idle(c_LAT + 4);
    chk("post_rst_ready", 64'(ready), 64'd1);
    chk("post_rst_valid", 64'(valid), 64'd0);
    chk("post_rst_overflow", 64'(overflow), 64'd0);

`ifdef IMEM_RESP_ISP_EN
    // Write lands on the same edge that 0x008 retires: old word first, new word afterwards.
    issue(12'h008, 1'b0);
    isp_write = 1'b1;
    isp_address = 12'h008;
    isp_data = 32'hDEADBEEF;
    tick();
    isp_write = 1'b0;
    m_mem[2] = 32'hDEADBEEF;
    idle(2);
    issue(12'h008, 1'b0);
    idle(c_LAT + 3);
`endif

    idle(4);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
